// File: rtl/seq_comparator.sv
// Sequential magnitude comparator: resolves A against B, CHUNK bits per clock, most significant chunk first.
// Optional macro SEQ_COMPARATOR_EARLY_EXIT_EN: leave CMP on the first mismatching chunk instead of scanning all.
// state | meaning
// IDLE  | waiting for start; last result held on agtb/aeqb/altb
// CMP   | comparing chunk r_idx, index counts down to 0
// DONE  | result registered, done pulses for this one cycle
module seq_comparator #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             agtb,
    output logic             aeqb,
    output logic             altb
);
    localparam int NCH  = WIDTH / CHUNK;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_signed;
    logic [IDXW-1:0]  r_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
    logic             r_found;
    logic             r_found_gt;
`endif

    logic [WIDTH-1:0] w_a_cmp;
    logic [WIDTH-1:0] w_b_cmp;
    logic [CHUNK-1:0] w_ca;
    logic [CHUNK-1:0] w_cb;
    logic             w_ne;
    logic             w_gt;
    logic             w_last;
    logic             w_res_ne;
    logic             w_res_gt;
    logic             w_finish;

    // Flipping both sign bits maps two's-complement order onto unsigned order; only the top chunk is affected.
    assign w_a_cmp = r_signed ? (r_a ^ MSB_MASK) : r_a;
    assign w_b_cmp = r_signed ? (r_b ^ MSB_MASK) : r_b;
    assign w_ca    = w_a_cmp[int'(r_idx)*CHUNK +: CHUNK];
    assign w_cb    = w_b_cmp[int'(r_idx)*CHUNK +: CHUNK];
    assign w_ne    = (w_ca != w_cb);
    assign w_gt    = (w_ca > w_cb);
    assign w_last  = (r_idx == '0);

`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
    assign w_res_ne = w_ne;
    assign w_res_gt = w_gt;
    assign w_finish = w_ne | w_last;
`else
    // The first mismatch wins; lower chunks are still scanned so latency stays fixed.
    assign w_res_ne = r_found | w_ne;
    assign w_res_gt = r_found ? r_found_gt : w_gt;
    assign w_finish = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_gt       <= 1'b0;
            r_eq       <= 1'b0;
            r_lt       <= 1'b0;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
            r_found    <= 1'b0;
            r_found_gt <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= CMP;
                        r_a        <= a;
                        r_b        <= b;
                        r_signed   <= signed_mode;
                        r_idx      <= IDX_TOP;
                        r_busy     <= 1'b1;
                        r_gt       <= 1'b0;
                        r_eq       <= 1'b0;
                        r_lt       <= 1'b0;
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
                        r_found    <= 1'b0;
                        r_found_gt <= 1'b0;
`endif
                    end
                end
                CMP: begin
`ifndef SEQ_COMPARATOR_EARLY_EXIT_EN
                    if (!r_found && w_ne) begin
                        r_found    <= 1'b1;
                        r_found_gt <= w_gt;
                    end
`endif
                    if (w_finish) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_gt    <= w_res_ne & w_res_gt;
                        r_lt    <= w_res_ne & ~w_res_gt;
                        r_eq    <= ~w_res_ne;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign agtb = r_gt;
    assign aeqb = r_eq;
    assign altb = r_lt;

endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: a WIDTH=4/CHUNK=1 and a WIDTH=8/CHUNK=2 instance checked every cycle against a transaction model.
module tb_seq_comparator;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       s4, sm4;
    logic [3:0] a4, b4;
    logic       busy4, done4, gt4, eq4, lt4;
    logic       s8, sm8;
    logic [7:0] a8, b8;
    logic       busy8, done8, gt8, eq8, lt8;

    seq_comparator #(.WIDTH(4), .CHUNK(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(s4), .signed_mode(sm4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .agtb(gt4), .aeqb(eq4), .altb(lt4));

    seq_comparator #(.WIDTH(8), .CHUNK(2)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .agtb(gt8), .aeqb(eq8), .altb(lt8));

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_LT = 3'b001;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference result straight from integer ordering of the operands.
    function automatic logic [2:0] ref_res(input int w, input logic sm, input logic [7:0] a, input logic [7:0] b);
        int va = int'(a);
        int vb = int'(b);
        if (sm && a[w-1]) va -= (1 << w);
        if (sm && b[w-1]) vb -= (1 << w);
        if (va > vb) return R_GT;
        if (va < vb) return R_LT;
        return R_EQ;
    endfunction

    // Number of CMP cycles: all chunks, or up to the chunk holding the highest differing bit.
    function automatic int ref_k(input int w, input int c, input logic [7:0] a, input logic [7:0] b);
        int nch = w / c;
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
        for (int i = w - 1; i >= 0; i--)
            if (a[i] != b[i]) return nch - i / c;
`endif
        return nch;
    endfunction

    // Model per instance: cycles left busy (k CMP + 1 DONE), pending and visible result.
    int         m_cnt [2] = '{0, 0};
    logic [2:0] m_pend[2] = '{3'b000, 3'b000};
    logic [2:0] m_res [2] = '{3'b000, 3'b000};

    task automatic step(input int d, input logic st, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input int w, input int c);
        if (m_cnt[d] == 0) begin
            if (st) begin
                m_cnt[d]  = ref_k(w, c, a, b) + 1;
                m_pend[d] = ref_res(w, sm, a, b);
                m_res[d]  = 3'b000;
            end
        end else begin
            m_cnt[d]--;
            if (m_cnt[d] == 1) m_res[d] = m_pend[d];
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            step(0, s4, sm4, {4'b0000, a4}, {4'b0000, b4}, 4, 1);
            step(1, s8, sm8, a8, b8, 8, 2);
        end
    end

    always @(negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            m_cnt[d]  = 0;
            m_pend[d] = 3'b000;
            m_res[d]  = 3'b000;
        end
    end

    always @(negedge clk) begin
        chk("cycle_w4", {27'd0, busy4, done4, gt4, eq4, lt4},
            {27'd0, m_cnt[0] != 0, m_cnt[0] == 1, m_res[0]});
        chk("cycle_w8", {27'd0, busy8, done8, gt8, eq8, lt8},
            {27'd0, m_cnt[1] != 0, m_cnt[1] == 1, m_res[1]});
    end

    // One transaction on the 4-bit instance; n counts cycles with the start cycle as 0.
    task automatic run4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                        output logic [2:0] res, output int n);
        s4 = 1'b0;
        @(negedge clk);
        s4 = 1'b1; sm4 = sm; a4 = a; b4 = b;
        n = 0; res = 3'b000;
        while (1) begin
            @(negedge clk);
            n++;
            s4 = 1'b0; sm4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
            if (done4) begin
                res = {gt4, eq4, lt4};
                break;
            end
            if (n > 40) begin
                chk("run4_timeout", 32'(n), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        logic [2:0] res;
        int         n;
        int         seen;
        int         ph;

        rst_n = 1'b1;
        s4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        s8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_state_w4", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
        rst_n = 1'b1;

        run4(1'b1, 4'b1000, 4'b1011, res, n); chk("signed_m8_vs_m5", res, R_LT);
        run4(1'b0, 4'b1000, 4'b1011, res, n); chk("unsigned_8_vs_11", res, R_LT);
        run4(1'b1, 4'b0101, 4'b1111, res, n); chk("signed_5_vs_m1", res, R_GT);
        run4(1'b0, 4'b0101, 4'b1111, res, n); chk("unsigned_5_vs_15", res, R_LT);
        run4(1'b1, 4'b0010, 4'b0010, res, n); chk("signed_eq", res, R_EQ);
        chk("signed_eq_latency", 32'(n), 32'd5);
        run4(1'b0, 4'b0010, 4'b0010, res, n); chk("unsigned_eq", res, R_EQ);
        chk("unsigned_eq_latency", 32'(n), 32'd5);
        run4(1'b0, 4'b1000, 4'b0000, res, n); chk("unsigned_8_vs_0", res, R_GT);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
        chk("msb_mismatch_latency", 32'(n), 32'd2);
`else
        chk("msb_mismatch_latency", 32'(n), 32'd5);
`endif

        // Reset in the second CMP cycle of an equal-operand compare.
        @(negedge clk);
        s4 = 1'b1; sm4 = 1'b0; a4 = 4'b0010; b4 = 4'b0010;
        @(negedge clk);
        s4 = 1'b0;
        @(negedge clk);
        chk("rst_precond_busy", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async_clear", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done4) seen = 1;
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done4) seen = 1;
        end
        chk("rst_no_done", 32'(seen), 32'd0);
        run4(1'b0, 4'b0111, 4'b0001, res, n); chk("after_rst_7_vs_1", res, R_GT);

        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run4(1'($urandom), 4'($urandom), ((i % 4) == 0) ? a4 : 4'($urandom), res, n);
        end

        // Start held high on the 8-bit instance, operands changing every cycle.
        @(negedge clk);
        s8 = 1'b1;
        ph = 0;
        for (int i = 0; i < 200; i++) begin
            sm8 = 1'($urandom); a8 = 8'($urandom);
            b8 = ((i % 5) == 0) ? a8 : 8'($urandom);
            @(negedge clk);
            if (ph == 1) begin
                chk("b2b_idle_gap", 32'(busy8), 32'd0);
                ph = 2;
            end else if (ph == 2) begin
                chk("b2b_reaccept", 32'(busy8), 32'd1);
                ph = 0;
            end
            if (done8) ph = 1;
        end
        s8 = 1'b0;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
